// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   start     in   request; accepted only in IDLE or DONE
//   dividend  in   [2*WIDTH-1:0] numerator, latched on accepted start
//   divisor   in   [WIDTH-1:0] denominator, latched on accepted start
//   busy      out  high while iterating
//   done      out  result valid; held until next accepted start or reset
//   overflow  out  divide-by-zero or quotient wider than WIDTH (valid with done)
//   quotient  out  [WIDTH-1:0] result quotient (valid with done)
//   remainder out  [WIDTH-1:0] result remainder (valid with done)
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITER_END = CW'(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] prem;     // partial remainder
  logic [WIDTH-1:0] shreg;    // low dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvsr;
  logic             ovf_pend; // overflow detected at accept; reported on the following edge

  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [WIDTH-1:0] trial_sub;
  logic             ovf_in;

  // The trial value is WIDTH+1 bits: its MSB can be set when divisor > 2^(WIDTH-1).
  // When trial >= divisor the difference is < divisor, so the low WIDTH bits suffice.
  always_comb begin
    trial     = {prem, shreg[WIDTH-1]};
    trial_ge  = (trial >= {1'b0, dvsr});
    trial_sub = trial[WIDTH-1:0] - dvsr;
    ovf_in    = (divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      count     <= '0;
      prem      <= '0;
      shreg     <= '0;
      dvsr      <= '0;
      ovf_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvsr      <= divisor;
            prem      <= dividend[2*WIDTH-1:WIDTH];
            shreg     <= dividend[WIDTH-1:0];
            count     <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf_pend  <= ovf_in;
            busy      <= !ovf_in;
            // The overflow path passes through RUN for one edge with busy low.
            state     <= RUN;
          end
        end

        RUN: begin
          if (ovf_pend) begin
            ovf_pend  <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
            overflow  <= 1'b1;
            quotient  <= '1;
            remainder <= shreg;
          end else if (count == ITER_END) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            overflow  <= 1'b0;
            quotient  <= shreg;
            remainder <= prem;
          end else begin
            prem  <= trial_ge ? trial_sub : trial[WIDTH-1:0];
            shreg <= {shreg[WIDTH-2:0], trial_ge};
            count <= count + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and random self-checking bench for seq_divider
module tb_seq_divider;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy, done, overflow;
  logic [W-1:0]   quotient, remainder;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .overflow(overflow), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept at edge 0; busy must hold and done stay low through edge W; done at edge W+1.
  task automatic do_normal(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] exp_q, input logic [W-1:0] exp_r);
    logic bad;
    dividend = dvd; divisor = dvs; start = 1'b1;
    step();
    start = 1'b0;
    bad = 1'b0;
    for (int e = 1; e <= W; e++) begin
      step();
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    end
    chk({tag, "_run_window"}, {63'd0, bad}, 64'd0);
    step();
    chk({tag, "_done"}, {62'd0, done, busy}, 64'd2);
    chk({tag, "_q"}, {48'd0, quotient}, {48'd0, exp_q});
    chk({tag, "_r"}, {48'd0, remainder}, {48'd0, exp_r});
    chk({tag, "_ovf"}, {63'd0, overflow}, 64'd0);
  endtask

  task automatic do_ovf(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    dividend = dvd; divisor = dvs; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_edge0"}, {62'd0, busy, done}, 64'd0);
    step();
    chk({tag, "_done"}, {61'd0, busy, done, overflow}, 64'd3);
    chk({tag, "_q"}, {48'd0, quotient}, 64'hFFFF);
    chk({tag, "_r"}, {48'd0, remainder}, {48'd0, dvd[W-1:0]});
  endtask

  initial begin
    logic bad;
    int   cyc;
    logic [W-1:0]   rd_dvs;
    logic [2*W-1:0] rd_dvd;
    logic [63:0]    recon;

    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    step();
    step();
    chk("reset_flags", {61'd0, busy, done, overflow}, 64'd0);
    chk("reset_q", {48'd0, quotient}, 64'd0);
    chk("reset_r", {48'd0, remainder}, 64'd0);
    reset = 1'b1;
    step();

    do_normal("div_100_7", 32'd100, 16'd7, 16'd14, 16'd2);
    // Outputs must hold while done with start low.
    step(); step(); step();
    chk("hold_done", {61'd0, done, busy, overflow}, 64'd4);
    chk("hold_qr", {32'd0, quotient, remainder}, {32'd0, 16'd14, 16'd2});

    do_normal("div_max", 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000);
    // 0x2468 * 0x8001 = 0x12342468, leaving remainder 0x3210; needs the 17-bit trial compare.
    do_normal("div_17bit", 32'h12345678, 16'h8001, 16'h2468, 16'h3210);

    do_ovf("ovf_div0", 32'h0000ABCD, 16'h0000);
    do_ovf("ovf_div1", 32'h00010000, 16'h0001);

    // start during RUN (cycle 5) with other operands must be ignored.
    dividend = 32'd100; divisor = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    dividend = 32'd5000; divisor = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    bad = 1'b0;
    for (int e = 6; e <= W; e++) begin
      step();
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    end
    chk("ignore_run_window", {63'd0, bad}, 64'd0);
    step();
    chk("ignore_done", {62'd0, done, busy}, 64'd2);
    chk("ignore_qr", {32'd0, quotient, remainder}, {32'd0, 16'd14, 16'd2});

    // Reset mid-run aborts with no partial result.
    dividend = 32'd100; divisor = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) step();
    reset = 1'b0;
    step();
    chk("abort_flags", {61'd0, busy, done, overflow}, 64'd0);
    chk("abort_qr", {32'd0, quotient, remainder}, 64'd0);
    reset = 1'b1;
    step();
    do_normal("div_1000_10", 32'd1000, 16'd10, 16'd100, 16'd0);

    // start held high across DONE: back-to-back operations.
    dividend = 32'd50; divisor = 16'd3; start = 1'b1;
    step();
    for (int e = 1; e <= W; e++) step();
    step();
    chk("held1_done", {62'd0, done, busy}, 64'd2);
    chk("held1_qr", {32'd0, quotient, remainder}, {32'd0, 16'd16, 16'd2});
    dividend = 32'd7; divisor = 16'd9;
    step();
    chk("held2_done_low", {63'd0, done}, 64'd0);
    for (int e = 1; e <= W; e++) step();
    step();
    start = 1'b0;
    chk("held2_done", {62'd0, done, busy}, 64'd2);
    chk("held2_qr", {32'd0, quotient, remainder}, {32'd0, 16'd0, 16'd7});

    // Random non-overflow sweep against the division invariant.
    for (int i = 0; i < 1000; i++) begin
      rd_dvs = W'($urandom_range(1, 65535));
      rd_dvd = {W'($urandom_range(0, int'(rd_dvs) - 1)), W'($urandom)};
      dividend = rd_dvd; divisor = rd_dvs; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
        step();
        cyc++;
      end
      recon = {48'd0, quotient} * {48'd0, rd_dvs} + {48'd0, remainder};
      chk($sformatf("rand%0d_latency", i), 64'(cyc), 64'd17);
      chk($sformatf("rand%0d_inv", i),
          {recon[61:0], overflow, (remainder < rd_dvs)},
          {30'd0, rd_dvd, 1'b0, 1'b1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
